noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Switch-allocation and output stage of a NOC router; sits directly downstream of the router's input-port FIFOs.
- Each input port presents its head-of-FIFO flit with a valid bit and a request bit, meaning "my packet targets this output".
- The block arbitrates round-robin among requesting inputs and locks the output to one packet, head flit through tail flit (wormhole).
- It pops the winning FIFO via a shift strobe and forwards flits over a registered, credit-flow-controlled link to the next router.

Parameters:
- NUM_IN, 5, number of input ports competing for this output (N/S/E/W/local).
- FLIT_W, 16, flit width in bits.
- CREDITS, 4, depth of the downstream input FIFO; initial credit count.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flit_i  input  NUM_IN x FLIT_W  head-of-FIFO flit per input.
- valid_i  input  NUM_IN  flit_i[k] is valid (FIFO non-empty).
- req_i  input  NUM_IN  input k's current packet is routed to this output; sampled only on head flits.
- shift_o  output  NUM_IN  one-hot-or-zero pop strobe to the input FIFOs; combinational.
- flit_o  output  FLIT_W  flit to the downstream link; registered.
- valid_o  output  1  flit_o valid; registered.
- credit_i  input  1  one-cycle pulse returning one downstream buffer slot.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- Flit type is flit[FLIT_W-1:FLIT_W-2]:
  - 01 = HEAD, 00 = BODY, 10 = TAIL, 11 = SINGLE (head and tail in one flit).
- Reset values:
  - flit_o = 0, valid_o = 0, err_o = 0.
  - Credit counter = CREDITS.
  - State = IDLE, owner = 0.
  - rr_ptr = NUM_IN-1, so input 0 has first priority.
- A transfer happens when shift_o[k] = 1. In the next cycle flit_o = flit_i[k] and valid_o = 1. Otherwise valid_o = 0 next cycle and flit_o holds its value.
- Latency is 1 cycle; throughput is at most 1 flit per cycle.
- Credit counter:
  - Width is $clog2(CREDITS+1).
  - Decrements on a transfer; increments on credit_i.
  - Transfer and credit_i in the same cycle: counter unchanged.
  - credit_i while the counter equals CREDITS: counter saturates and err_o is set.
  - No transfer is allowed while the counter is 0.
- FSM state IDLE:
  - Candidates are inputs with valid_i & req_i & type in {HEAD, SINGLE}.
  - Search order is rr_ptr+1, rr_ptr+2, ... wrapping mod NUM_IN; the first candidate wins.
  - If credits > 0, the winner is shifted in the same cycle and rr_ptr becomes the winner.
  - A HEAD winner moves the FSM to LOCKED with owner = winner. A SINGLE winner leaves the FSM in IDLE.
  - If credits = 0, there is no grant and rr_ptr is unchanged.
  - Any input with valid_i & req_i showing BODY/TAIL in IDLE is not shifted and sets err_o.
- FSM state LOCKED:
  - Only the owner is served; req_i and all other inputs are ignored.
  - When valid_i[owner] and credits > 0, shift the owner.
  - If the transferred flit is TAIL, return to IDLE.
  - A HEAD or SINGLE at the owner while LOCKED is not shifted, sets err_o, and the FSM stays LOCKED.
  - An owner bubble (valid_i = 0) holds LOCKED indefinitely; there is no timeout.
- Arbitration is re-evaluated from IDLE in the cycle after a tail transfer; there is no back-to-back same-cycle re-grant.
- shift_o must never assert for an input with valid_i = 0.
- rst mid-packet returns all state to reset values. The downstream router is reset together with this block, which is why credits return to CREDITS.

Optional Feature:
- Macro NOC_OUT_STATS_EN.
- When defined, two extra outputs are added:
  - pkt_cnt_o (32 bits): counts TAIL and SINGLE transfers.
  - stall_cnt_o (32 bits): counts cycles with a pending candidate or owner flit blocked by zero credits.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package noc_pkg holds:
  - FLIT_W.
  - Enum flit_type_t {BODY=2'b00, HEAD=2'b01, TAIL=2'b10, SINGLE=2'b11}.
  - Function flit_type(flit).
  - Enum arb_state_t {IDLE, LOCKED}.
- Sub-module noc_rr_arbiter (NUM_IN): inputs req vector and ptr; outputs one-hot grant and grant index; purely combinational.
- Pointer update and FSM stay in the parent.

Test Plan:
- Single SINGLE flit 16'hC0AB on input 2 with req, credits 4 → shift_o = 5'b00100 at cycle t; flit_o = 16'hC0AB, valid_o = 1 at t+1; credits = 3.
- Inputs 0 and 3 each send HEAD/BODY/TAIL simultaneously → input 0's 3 flits appear contiguously, then input 3's; no interleave. A later simultaneous request from 0 and 3 grants 3 first.
- CREDITS = 4, no credit_i, 6-flit packet → 4 flits transfer, then shift_o = 0 and valid_o = 0. One credit_i pulse → exactly 1 more flit next cycle.
- Credit return and transfer in the same cycle with counter at 2 → counter stays 2. credit_i at counter 4 → err_o = 1 and counter stays 4.
- BODY flit with req on input 1 while IDLE → no shift, err_o = 1, other inputs still arbitrated.
- rst asserted after the HEAD of a 3-flit packet → next cycle valid_o = 0, state IDLE, credits = 4; input 0 wins the next arbitration.

Source files
------------

// File: rtl/noc_output_arbiter_pkg.sv
// Shared flit definitions for the NOC output stage: flit type encoding and arbiter states.
package noc_pkg;

  localparam int FLIT_W = 16;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // The type field sits in the two most significant bits of every flit.
  function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_t'(flit[FLIT_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Input-FIFO heads, pop strobes and the credit-controlled downstream link of one router output.
// The NOC_OUT_STATS_EN build adds the packet and stall counters.
interface noc_output_arbiter_if #(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = 16
);
    logic [NUM_IN-1:0][FLIT_W-1:0] flit_i;
    logic [NUM_IN-1:0]             valid_i;
    logic [NUM_IN-1:0]             req_i;
    logic [NUM_IN-1:0]             shift_o;
    logic [FLIT_W-1:0]             flit_o;
    logic                          valid_o;
    logic                          credit_i;
    logic                          err_o;
`ifdef NOC_OUT_STATS_EN
    logic [31:0]                   pkt_cnt_o;
    logic [31:0]                   stall_cnt_o;

    modport slave  (input  flit_i, valid_i, req_i, credit_i,
                    output shift_o, flit_o, valid_o, err_o, pkt_cnt_o, stall_cnt_o);
    modport master (output flit_i, valid_i, req_i, credit_i,
                    input  shift_o, flit_o, valid_o, err_o, pkt_cnt_o, stall_cnt_o);
`else
    modport slave  (input  flit_i, valid_i, req_i, credit_i,
                    output shift_o, flit_o, valid_o, err_o);
    modport master (output flit_i, valid_i, req_i, credit_i,
                    input  shift_o, flit_o, valid_o, err_o);
`endif
endinterface

// File: rtl/noc_output_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_ptr, wrapping, wins.
module noc_rr_arbiter #(
    parameter int NUM_IN = 5,
    parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_IN-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_gnt_idx
);
    int w_k;

    // Scan farthest-first so the nearest requester after i_ptr is the last write.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_k       = 0;
        for (int i = NUM_IN; i >= 1; i--) begin
            w_k = (int'(i_ptr) + i) % NUM_IN;
            if (i_req[w_k]) begin
                o_gnt      = '0;
                o_gnt[w_k] = 1'b1;
                o_gnt_idx  = IDX_W'(w_k);
            end
        end
    end
endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole switch allocation and registered, credit-flow-controlled output of one NOC router port.
// Define NOC_OUT_STATS_EN to add the pkt_cnt_o / stall_cnt_o counters.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int FLIT_W  = noc_pkg::FLIT_W,
    parameter int CREDITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_output_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_cred;
    logic [FLIT_W-1:0] r_flit;
    logic              r_valid;
    logic              r_err;

    flit_type_t        w_type [NUM_IN];
    logic [NUM_IN-1:0] w_head;
    logic [NUM_IN-1:0] w_cand;
    logic [NUM_IN-1:0] w_bad;
    logic [NUM_IN-1:0] w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [NUM_IN-1:0] w_shift;
    logic [IDX_W-1:0]  w_sel;
    logic              w_err_now;
    logic              w_has_cr;
    logic              w_own_vld;
    logic              w_own_head;
    logic              w_xfer;
    logic              w_cr_ovf;
    logic [FLIT_W-1:0] w_xfer_flit;
    flit_type_t        w_xfer_type;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            w_type[k] = flit_type(bus.flit_i[k]);
            w_head[k] = (w_type[k] == HEAD) || (w_type[k] == SINGLE);
        end
    end

    assign w_cand     = bus.valid_i & bus.req_i & w_head;
    assign w_bad      = bus.valid_i & bus.req_i & ~w_head;
    assign w_has_cr   = (r_cred != '0);
    assign w_own_vld  = bus.valid_i[r_owner];
    assign w_own_head = w_head[r_owner];

    noc_rr_arbiter #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_rr_arbiter (
        .i_req     (w_cand),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // Pop decision: arbitration result when idle, only the owner's body/tail when locked.
    always_comb begin
        w_shift   = '0;
        w_sel     = r_owner;
        w_err_now = 1'b0;
        if (r_state == IDLE) begin
            w_sel     = w_gnt_idx;
            w_err_now = |w_bad;
            if (w_has_cr) w_shift = w_gnt;
        end else if (w_own_vld) begin
            if (w_own_head)    w_err_now        = 1'b1;
            else if (w_has_cr) w_shift[r_owner] = 1'b1;
        end
    end

    assign w_xfer      = |w_shift;
    assign w_xfer_flit = bus.flit_i[w_sel];
    assign w_xfer_type = w_type[w_sel];
    // A returned credit with every slot already free means the neighbour miscounted.
    assign w_cr_ovf    = bus.credit_i && !w_xfer && (r_cred == CNT_W'(CREDITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= IDX_W'(NUM_IN - 1);
            r_cred   <= CNT_W'(CREDITS);
            r_flit   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= w_xfer;
            if (w_xfer) r_flit <= w_xfer_flit;
            if (w_err_now || w_cr_ovf) r_err <= 1'b1;

            case ({w_xfer, bus.credit_i})
                2'b10:   r_cred <= r_cred - CNT_W'(1);
                2'b01:   if (!w_cr_ovf) r_cred <= r_cred + CNT_W'(1);
                default: ;
            endcase

            case (r_state)
                IDLE: if (w_xfer) begin
                    r_rr_ptr <= w_gnt_idx;
                    if (w_xfer_type == HEAD) begin
                        r_state <= LOCKED;
                        r_owner <= w_gnt_idx;
                    end
                end
                LOCKED: if (w_xfer && (w_xfer_type == TAIL)) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.shift_o = w_shift;
    assign bus.flit_o  = r_flit;
    assign bus.valid_o = r_valid;
    assign bus.err_o   = r_err;

`ifdef NOC_OUT_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = !w_has_cr &&
                     (((r_state == IDLE) && |w_cand) ||
                      ((r_state == LOCKED) && w_own_vld && !w_own_head));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer && ((w_xfer_type == TAIL) || (w_xfer_type == SINGLE)))
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.pkt_cnt_o   = r_pkt_cnt;
    assign bus.stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed test-plan scenarios followed by randomized packet traffic against a queue-based reference.
module tb_noc_output_arbiter;
  localparam int N  = 5;
  localparam int W  = 16;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_output_arbiter_if #(.NUM_IN(N), .FLIT_W(W)) bus();
  noc_output_arbiter #(.NUM_IN(N), .FLIT_W(W), .CREDITS(CR)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // upstream FIFOs, output log, stimulus knobs
  logic [W-1:0] q [N][$];
  logic [W-1:0] out_log [$];
  bit rnd = 0, refill_en = 0, cr_once = 0;
  int cr_mode = 0;  // 0 none, 1 return whenever outstanding, 2 random return
  int seqn = 0;

  // reference model state
  bit m_locked, m_err, m_vld;
  int m_owner, m_rr, m_cred;
  logic [W-1:0] m_flit;
  logic [N-1:0] m_shift;

  logic [N-1:0] obs_shift;
  logic obs_vld, obs_err;
  logic [W-1:0] obs_flit;
  int obs_cred;

  function automatic logic [W-1:0] fl(input logic [1:0] t, input int src);
    logic [2:0] s;
    logic [10:0] n;
    s = src[2:0];
    n = seqn[10:0];
    seqn++;
    return {t, s, n};
  endfunction

  function automatic bit is_hd(input logic [W-1:0] f);
    return f[W-2];  // HEAD (01) and SINGLE (11) both have the low type bit set
  endfunction

  task automatic push_pkt(input int k, input int len);
    if (len == 1) q[k].push_back(fl(2'b11, k));
    else begin
      q[k].push_back(fl(2'b01, k));
      for (int i = 0; i < len - 2; i++) q[k].push_back(fl(2'b00, k));
      q[k].push_back(fl(2'b10, k));
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = N - 1; m_cred = CR;
    m_err = 0; m_vld = 0; m_flit = '0;
  endtask

  function automatic logic [N-1:0] ref_shift();
    logic [N-1:0] s = '0;
    if (m_cred == 0) return s;
    if (m_locked) begin
      if (bus.valid_i[m_owner] && !is_hd(bus.flit_i[m_owner])) s[m_owner] = 1'b1;
      return s;
    end
    for (int i = 1; i <= N; i++) begin
      int k = (m_rr + i) % N;
      if (bus.valid_i[k] && bus.req_i[k] && is_hd(bus.flit_i[k])) begin
        s[k] = 1'b1;
        return s;
      end
    end
    return s;
  endfunction

  task automatic model_update(input logic [N-1:0] sh);
    int k = -1;
    logic [1:0] t;
    for (int i = 0; i < N; i++) if (sh[i]) k = i;
    if (!m_locked) begin
      for (int i = 0; i < N; i++)
        if (bus.valid_i[i] && bus.req_i[i] && !is_hd(bus.flit_i[i])) m_err = 1;
    end else if (bus.valid_i[m_owner] && is_hd(bus.flit_i[m_owner])) m_err = 1;
    if (k >= 0 && !bus.credit_i) m_cred--;
    else if (k < 0 && bus.credit_i) begin
      if (m_cred == CR) m_err = 1;
      else m_cred++;
    end
    m_vld = (k >= 0);
    if (k >= 0) begin
      m_flit = bus.flit_i[k];
      t = m_flit[W-1 -: 2];
      if (!m_locked) begin
        m_rr = k;
        if (t == 2'b01) begin m_locked = 1; m_owner = k; end
      end else if (t == 2'b10) m_locked = 0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bit has = q[k].size() > 0;
      bus.valid_i[k] = has && (!rnd || $urandom_range(0, 9) < 8);
      bus.flit_i[k]  = has ? q[k][0] : W'($urandom);
      bus.req_i[k]   = rnd ? ($urandom_range(0, 9) < 8) : has;
    end
    case (cr_mode)
      1:       bus.credit_i = (m_cred < CR);
      2:       bus.credit_i = (m_cred < CR) && ($urandom_range(0, 2) == 0);
      default: bus.credit_i = 1'b0;
    endcase
    if (cr_once) begin bus.credit_i = 1'b1; cr_once = 0; end
  endtask

  task automatic step();
    @(negedge clk);
    m_shift   = ref_shift();
    obs_shift = bus.shift_o;
    obs_vld   = bus.valid_o;
    obs_flit  = bus.flit_o;
    obs_err   = bus.err_o;
    obs_cred  = int'(dut.r_cred);
    chk("shift_o", obs_shift, m_shift);
    chk("valid_o", obs_vld, m_vld);
    chk("flit_o", obs_flit, m_flit);
    chk("err_o", obs_err, m_err);
    chk("credits", obs_cred, m_cred);
    if (obs_vld) out_log.push_back(obs_flit);
    model_update(m_shift);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) if (m_shift[k] && q[k].size() > 0) void'(q[k].pop_front());
    if (refill_en)
      for (int k = 0; k < N; k++)
        if (q[k].size() < 4 && $urandom_range(0, 7) == 0) push_pkt(k, $urandom_range(1, 5));
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) q[k].delete();
    cr_once = 0;
    drive();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    out_log.delete();
    drive();
  endtask

  logic [W-1:0] exp_ord [$];
  logic [2:0] src0, src1;
  int left;

  initial begin
    model_reset();
    bus.credit_i = 1'b0;
    drive();

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid_o", bus.valid_o, 1'b0);
    chk("rst_flit_o", bus.flit_o, '0);
    chk("rst_err_o", bus.err_o, 1'b0);
    chk("rst_credits", int'(dut.r_cred), CR);
    @(posedge clk); #1;

    // single SINGLE flit on input 2
    q[2].push_back(16'hC0AB);
    drive();
    step();
    chk("t1_shift", obs_shift, 5'b00100);
    step();
    chk("t1_valid", obs_vld, 1'b1);
    chk("t1_flit", obs_flit, 16'hC0AB);
    chk("t1_cred", obs_cred, 3);

    // two simultaneous 3-flit packets: no interleave, input 0 first
    do_reset();
    cr_mode = 1;
    push_pkt(0, 3); push_pkt(3, 3);
    foreach (q[0][i]) exp_ord.push_back(q[0][i]);
    foreach (q[3][i]) exp_ord.push_back(q[3][i]);
    drive();
    repeat (10) step();
    chk("t2_count", out_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_order%0d", i), (i < out_log.size()) ? out_log[i] : 'x, exp_ord[i]);
    push_pkt(0, 1);
    drive();
    repeat (4) step();
    out_log.delete();
    push_pkt(0, 1); push_pkt(3, 1);
    drive();
    repeat (5) step();
    chk("t2_rr_count", out_log.size(), 2);
    src0 = (out_log.size() > 0) ? out_log[0][13:11] : 3'bx;
    src1 = (out_log.size() > 1) ? out_log[1][13:11] : 3'bx;
    chk("t2_rr_first", src0, 3'd3);
    chk("t2_rr_second", src1, 3'd0);

    // credit exhaustion on a 6-flit packet, then a single credit return
    do_reset();
    cr_mode = 0;
    push_pkt(1, 6);
    drive();
    repeat (8) step();
    chk("t3_sent", out_log.size(), 4);
    chk("t3_stalled_shift", obs_shift, '0);
    chk("t3_stalled_valid", obs_vld, 1'b0);
    cr_once = 1;
    drive();
    repeat (4) step();
    chk("t3_one_more", out_log.size(), 5);

    // credit return coinciding with a transfer at counter 2
    do_reset();
    push_pkt(0, 3);
    drive();
    step(); step();
    cr_once = 1;
    drive();
    step();
    chk("t4_pre_cred", obs_cred, 2);
    step();
    chk("t4_same_cycle", obs_cred, 2);

    // credit return with all slots free
    do_reset();
    cr_once = 1;
    drive();
    step(); step();
    chk("t4_ovf_err", obs_err, 1'b1);
    chk("t4_ovf_cred", obs_cred, CR);

    // stray BODY with req while idle; input 3 still arbitrated
    do_reset();
    q[1].push_back(fl(2'b00, 1));
    push_pkt(3, 1);
    drive();
    step();
    chk("t5_shift", obs_shift, 5'b01000);
    step();
    chk("t5_err", obs_err, 1'b1);
    chk("t5_flit_valid", obs_vld, 1'b1);

    // reset in the middle of a packet
    do_reset();
    cr_mode = 1;
    push_pkt(2, 3);
    drive();
    step();
    do_reset();
    push_pkt(0, 1); push_pkt(4, 1);
    drive();
    step();
    chk("t6_valid", obs_vld, 1'b0);
    chk("t6_cred", obs_cred, CR);
    chk("t6_state", dut.r_state, 1'b0);
    chk("t6_winner", obs_shift, 5'b00001);

    // randomized traffic with bubbles, req noise and random credit return
    do_reset();
    rnd = 1; refill_en = 1; cr_mode = 2;
    drive();
    repeat (3000) step();
    refill_en = 0;
    cr_mode = 1;
    left = 0;
    for (int i = 0; i < 1000; i++) begin
      left = 0;
      for (int k = 0; k < N; k++) left += q[k].size();
      if (left == 0) break;
      step();
    end
    chk("drain_empty", left, 0);
    chk("rand_no_err", bus.err_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
